// File: rtl/jesd204_up_axi_master.sv
// JESD204 uP AXI4-Lite initiator, one transaction in flight.
// Optional response timeout: define JESD204_AXI_MASTER_TIMEOUT_EN.
module jesd204_up_axi_master #(
   parameter int AXI_ADDRESS_WIDTH = 14,
   parameter int TIMEOUT_CYCLES    = 1024
) (
   input  logic                         up_clk,
   input  logic                         up_rstn,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_write,
   input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
   input  logic [31:0]                  cmd_wdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [31:0]                  rsp_rdata,
   output logic [1:0]                   rsp_resp,
   output logic                         rsp_timeout,
   output logic                         m_axi_awvalid,
   output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]                   m_axi_awprot,
   input  logic                         m_axi_awready,
   output logic                         m_axi_wvalid,
   output logic [31:0]                  m_axi_wdata,
   output logic [3:0]                   m_axi_wstrb,
   input  logic                         m_axi_wready,
   input  logic                         m_axi_bvalid,
   input  logic [1:0]                   m_axi_bresp,
   output logic                         m_axi_bready,
   output logic                         m_axi_arvalid,
   output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]                   m_axi_arprot,
   input  logic                         m_axi_arready,
   input  logic                         m_axi_rvalid,
   input  logic [31:0]                  m_axi_rdata,
   input  logic [1:0]                   m_axi_rresp,
   output logic                         m_axi_rready
);

   localparam int AW = AXI_ADDRESS_WIDTH;
   localparam logic [AW-1:0] AMASK = {{(AW-2){1'b1}}, 2'b00};

   typedef enum logic [2:0] {
      IDLE, WADDR, WRESP, RADDR, RDATA, RESP
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          aw_done_q, aw_done_d;
   logic          w_done_q, w_done_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [1:0]    resp_q, resp_d;

`ifdef JESD204_AXI_MASTER_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        tmo_q, tmo_d;
   logic        busy;
   assign busy = (state_q == WADDR) || (state_q == WRESP) ||
                 (state_q == RADDR) || (state_q == RDATA);
`else
   localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

   // Next-state, capture and timeout override
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d    = cmd_addr & AMASK;
               wdata_d   = cmd_wdata;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cmd_write ? WADDR : RADDR;
            end
         end
         WADDR: begin
            if (m_axi_awready) aw_done_d = 1'b1;
            if (m_axi_wready)  w_done_d  = 1'b1;
            if ((aw_done_q || m_axi_awready) &&
                (w_done_q || m_axi_wready))
               state_d = WRESP;
         end
         WRESP: begin
            if (m_axi_bvalid) begin
               resp_d  = m_axi_bresp;
               rdata_d = '0;
               state_d = RESP;
            end
         end
         RADDR: begin
            if (m_axi_arready) state_d = RDATA;
         end
         RDATA: begin
            if (m_axi_rvalid) begin
               resp_d  = m_axi_rresp;
               rdata_d = m_axi_rdata;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef JESD204_AXI_MASTER_TIMEOUT_EN
      tmo_d = tmo_q;
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
         tmo_d = 1'b0;
      end else if (busy) begin
         cnt_d = cnt_q + 16'd1;
      end
      // a busy state that made no progress this cycle
      if (busy && state_d == state_q &&
          cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
         state_d = RESP;
         resp_d  = 2'b10;
         rdata_d = '0;
         tmo_d   = 1'b1;
      end
`endif
   end

   // State and captured fields
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
      end
   end

`ifdef JESD204_AXI_MASTER_TIMEOUT_EN
   // Response wait counter and timeout flag
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end
   assign rsp_timeout = tmo_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   assign cmd_ready     = (state_q == IDLE) && up_rstn;
   assign rsp_valid     = (state_q == RESP);
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign m_axi_awvalid = (state_q == WADDR) && !aw_done_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_wvalid  = (state_q == WADDR) && !w_done_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = 4'hf;
   assign m_axi_bready  = (state_q == WRESP);
   assign m_axi_arvalid = (state_q == RADDR);
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_rready  = (state_q == RDATA);

endmodule

// File: tb/tb_jesd204_up_axi_master.sv
// Bench for jesd204_up_axi_master: vector table,
// random transactions and reset/timeout sequences.
module tb_jesd204_up_axi_master;

   localparam int AW  = 14;
   localparam int TMO = 16;

   logic          up_clk = 1'b0;
   logic          up_rstn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          m_axi_awvalid, m_axi_awready;
   logic [AW-1:0] m_axi_awaddr;
   logic [2:0]    m_axi_awprot;
   logic          m_axi_wvalid, m_axi_wready;
   logic [31:0]   m_axi_wdata;
   logic [3:0]    m_axi_wstrb;
   logic          m_axi_bvalid, m_axi_bready;
   logic [1:0]    m_axi_bresp;
   logic          m_axi_arvalid, m_axi_arready;
   logic [AW-1:0] m_axi_araddr;
   logic [2:0]    m_axi_arprot;
   logic          m_axi_rvalid, m_axi_rready;
   logic [31:0]   m_axi_rdata;
   logic [1:0]    m_axi_rresp;

   int checks = 0;
   int errors = 0;

   jesd204_up_axi_master #(
      .AXI_ADDRESS_WIDTH(AW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .up_clk(up_clk), .up_rstn(up_rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .rsp_timeout(rsp_timeout),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awprot(m_axi_awprot), .m_axi_awready(m_axi_awready),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_wready(m_axi_wready),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp),
      .m_axi_bready(m_axi_bready),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
      .m_axi_arprot(m_axi_arprot), .m_axi_arready(m_axi_arready),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rready(m_axi_rready)
   );

   always #5 up_clk = ~up_clk;

   typedef struct {
      bit          wr;
      logic [13:0] addr;
      logic [31:0] wdata;
      int          aw_w, w_w, b_w, ar_w, r_w;
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          rsp_w;
      bit          noise;
      int          lat;
      logic [31:0] e_rdata;
      logic [1:0]  e_resp;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", n, a, e);
      end
   endtask

   function automatic vec_t mk(
      input bit wr, input logic [13:0] a, input logic [31:0] d,
      input int aw, input int w, input int b, input int ar,
      input int r, input logic [1:0] rs, input logic [31:0] rd,
      input int rw, input bit nz, input int lat,
      input logic [31:0] erd, input logic [1:0] ers);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d;
      v.aw_w = aw; v.w_w = w; v.b_w = b;
      v.ar_w = ar; v.r_w = r;
      v.resp = rs; v.rdata = rd;
      v.rsp_w = rw; v.noise = nz;
      v.lat = lat; v.e_rdata = erd; v.e_resp = ers;
      return v;
   endfunction

   // Reference: a transaction costs accept + one cycle per
   // channel stage plus responder waits; writes wait for the
   // slower of AW/W. Writes report zero data.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int   m;
      r = v;
      if (v.wr) begin
         m = (v.aw_w > v.w_w) ? v.aw_w : v.w_w;
         r.lat = 3 + m + v.b_w;
         r.e_rdata = 32'h0;
      end else begin
         r.lat = 3 + v.ar_w + v.r_w;
         r.e_rdata = v.rdata;
      end
      r.e_resp = v.resp;
      return r;
   endfunction

   task automatic idle_inputs();
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
   endtask

   task automatic chk_reset_outs(input string n);
      chk(n, {cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
              rsp_timeout, m_axi_awvalid, m_axi_wvalid,
              m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
   endtask

   task automatic run(input vec_t v, input string tag);
      int cyc, awc, wc, bc, arc, rc;
      int n_aw, n_w, n_b, n_ar, n_r;
      bit aw_ok, w_ok, b_ok, ar_ok, r_ok;
      bit aw_pend, ar_pend;
      logic [13:0] ea;
      ea = {v.addr[13:2], 2'b00};
      cyc = 0; awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
      n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
      aw_ok = 0; w_ok = 0; b_ok = 0; ar_ok = 0; r_ok = 0;
      aw_pend = 0; ar_pend = 0;
      m_axi_bresp = v.resp;
      m_axi_rresp = v.resp;
      m_axi_rdata = v.rdata;
      @(negedge up_clk);
      chk({tag, " cmd_ready idle"}, cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      while (!rsp_valid && cyc < 100) begin
         @(negedge up_clk);
         cyc++;
         if (v.noise) begin
            cmd_write = ~v.wr;
            cmd_addr  = ~v.addr;
            cmd_wdata = ~v.wdata;
         end else begin
            cmd_valid = 1'b0;
         end
         chk({tag, " cmd_ready busy"}, cmd_ready, 0);
         if (aw_pend)
            chk({tag, " awvalid hold"}, m_axi_awvalid, 1);
         if (ar_pend)
            chk({tag, " arvalid hold"}, m_axi_arvalid, 1);
         m_axi_bvalid = 1'b0;
         if (aw_ok && w_ok && !b_ok) begin
            m_axi_bvalid = (bc >= v.b_w);
            bc++;
         end
         if (m_axi_bvalid && m_axi_bready) begin
            n_b++;
            b_ok = 1;
         end
         m_axi_rvalid = 1'b0;
         if (ar_ok && !r_ok) begin
            m_axi_rvalid = (rc >= v.r_w);
            rc++;
         end
         if (m_axi_rvalid && m_axi_rready) begin
            n_r++;
            r_ok = 1;
         end
         m_axi_awready = m_axi_awvalid && (awc >= v.aw_w);
         if (m_axi_awvalid) awc++;
         aw_pend = m_axi_awvalid && !m_axi_awready;
         if (m_axi_awvalid && m_axi_awready) begin
            n_aw++;
            aw_ok = 1;
            chk({tag, " awaddr"}, m_axi_awaddr, ea);
            chk({tag, " awprot"}, m_axi_awprot, 0);
         end
         m_axi_wready = m_axi_wvalid && (wc >= v.w_w);
         if (m_axi_wvalid) wc++;
         if (m_axi_wvalid && m_axi_wready) begin
            n_w++;
            w_ok = 1;
            chk({tag, " wdata"}, m_axi_wdata, v.wdata);
            chk({tag, " wstrb"}, m_axi_wstrb, 4'hf);
         end
         m_axi_arready = m_axi_arvalid && (arc >= v.ar_w);
         if (m_axi_arvalid) arc++;
         ar_pend = m_axi_arvalid && !m_axi_arready;
         if (m_axi_arvalid && m_axi_arready) begin
            n_ar++;
            ar_ok = 1;
            chk({tag, " araddr"}, m_axi_araddr, ea);
            chk({tag, " arprot"}, m_axi_arprot, 0);
         end
      end
      idle_inputs();
      chk({tag, " rsp_valid"}, rsp_valid, 1);
      chk({tag, " latency"}, cyc, v.lat);
      chk({tag, " rdata"}, rsp_rdata, v.e_rdata);
      chk({tag, " resp"}, rsp_resp, v.e_resp);
      chk({tag, " timeout"}, rsp_timeout, 0);
      for (int h = 0; h < v.rsp_w; h++) begin
         @(negedge up_clk);
         chk({tag, " hold valid"}, rsp_valid, 1);
         chk({tag, " hold rdata"}, rsp_rdata, v.e_rdata);
         chk({tag, " hold resp"}, rsp_resp, v.e_resp);
         chk({tag, " hold cmd_ready"}, cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      @(negedge up_clk);
      rsp_ready = 1'b0;
      chk({tag, " rsp done"}, rsp_valid, 0);
      chk({tag, " back idle"}, cmd_ready, 1);
      chk({tag, " n_aw"}, n_aw, v.wr ? 1 : 0);
      chk({tag, " n_w"}, n_w, v.wr ? 1 : 0);
      chk({tag, " n_b"}, n_b, v.wr ? 1 : 0);
      chk({tag, " n_ar"}, n_ar, v.wr ? 0 : 1);
      chk({tag, " n_r"}, n_r, v.wr ? 0 : 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      up_rstn     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_addr    = '0;
      cmd_wdata   = '0;
      rsp_ready   = 1'b0;
      m_axi_bresp = '0;
      m_axi_rdata = '0;
      m_axi_rresp = '0;
      idle_inputs();

      //            wr addr     wdata        aw w b ar r rs
      //            rdata        rw nz lat erdata       eresp
      tbl[0] = mk(1, 14'h0210, 32'h0000_0003, 0, 0, 0, 0, 0,
                  2'b00, 32'h0, 0, 0, 3, 32'h0, 2'b00);
      tbl[1] = mk(0, 14'h0000, 32'h0, 0, 0, 0, 5, 0,
                  2'b00, 32'h0001_0661, 0, 0, 8,
                  32'h0001_0661, 2'b00);
      tbl[2] = mk(1, 14'h0104, 32'h1234_abcd, 4, 0, 0, 0, 0,
                  2'b00, 32'h0, 0, 0, 7, 32'h0, 2'b00);
      tbl[3] = mk(0, 14'h0020, 32'h0, 0, 0, 0, 0, 0,
                  2'b10, 32'hcafe_0001, 10, 1, 3,
                  32'hcafe_0001, 2'b10);
      tbl[4] = mk(1, 14'h0300, 32'hffff_ffff, 0, 0, 2, 0, 0,
                  2'b11, 32'h0, 1, 0, 5, 32'h0, 2'b11);
      tbl[5] = mk(0, 14'h3fff, 32'h0, 0, 0, 0, 1, 2,
                  2'b00, 32'h1234_5678, 0, 0, 6,
                  32'h1234_5678, 2'b00);
      tbl[6] = mk(1, 14'h0213, 32'h5a5a_0f0f, 1, 3, 0, 0, 0,
                  2'b01, 32'h0, 2, 1, 6, 32'h0, 2'b01);
      tbl[7] = mk(0, 14'h1002, 32'h0, 0, 0, 0, 0, 3,
                  2'b11, 32'h8000_0000, 0, 0, 6,
                  32'h8000_0000, 2'b11);

      repeat (2) @(negedge up_clk);
      chk_reset_outs("reset outs");
      up_rstn = 1'b1;
      @(negedge up_clk);
      chk("cmd_ready after reset", cmd_ready, 1);

      for (int i = 0; i < 8; i++) begin
         run(tbl[i], $sformatf("vec%0d", i));
      end

      // reset pulsed while waiting for the write response
      @(negedge up_clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 14'h0100;
      cmd_wdata = 32'hdead_beef;
      @(negedge up_clk);
      cmd_valid = 1'b0;
      m_axi_awready = 1'b1;
      m_axi_wready  = 1'b1;
      @(negedge up_clk);
      idle_inputs();
      chk("rst seq in wresp", m_axi_bready, 1);
      up_rstn = 1'b0;
      #1;
      chk_reset_outs("rst seq immediate");
      @(negedge up_clk);
      chk_reset_outs("rst seq held");
      up_rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge up_clk);
         chk("rst seq no rsp", rsp_valid, 0);
         chk("rst seq cmd_ready", cmd_ready, 1);
         chk("rst seq no bready", m_axi_bready, 0);
      end
      run(tbl[0], "post-reset");

`ifdef JESD204_AXI_MASTER_TIMEOUT_EN
      begin
         int n;
         int cyc;
         n = 0;
         cyc = 0;
         @(negedge up_clk);
         cmd_valid = 1'b1;
         cmd_write = 1'b0;
         cmd_addr  = 14'h0040;
         do begin
            @(negedge up_clk);
            cyc++;
            cmd_valid = 1'b0;
            if (m_axi_arvalid) n++;
         end while (!rsp_valid && cyc < 100);
         chk("tmo arvalid cycles", n, TMO);
         chk("tmo rsp_valid", rsp_valid, 1);
         chk("tmo arvalid low", m_axi_arvalid, 0);
         chk("tmo flag", rsp_timeout, 1);
         chk("tmo resp", rsp_resp, 2'b10);
         chk("tmo rdata", rsp_rdata, 0);
         rsp_ready = 1'b1;
         @(negedge up_clk);
         rsp_ready = 1'b0;
         chk("tmo back idle", cmd_ready, 1);
      end
`endif

      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v.wr    = 1'($urandom_range(0, 1));
         v.addr  = 14'($urandom);
         v.wdata = $urandom;
         v.aw_w  = $urandom_range(0, 3);
         v.w_w   = $urandom_range(0, 3);
         v.b_w   = $urandom_range(0, 3);
         v.ar_w  = $urandom_range(0, 3);
         v.r_w   = $urandom_range(0, 3);
         v.resp  = 2'($urandom);
         v.rdata = $urandom;
         v.rsp_w = $urandom_range(0, 3);
         v.noise = 1'($urandom_range(0, 1));
         v = model(v);
         run(v, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jesd204_up_axi_master.md
JESD204_UP_AXI_MASTER -- requirements
Module: jesd204_up_axi_master

Interface
REQ-001 SHALL have parameter AXI_ADDRESS_WIDTH, default 14: width of cmd_addr, m_axi_awaddr and m_axi_araddr (byte address).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: response wait limit; legal range 2..65535.
REQ-003 SHALL have up_clk, input, 1: single clock for all logic.
REQ-004 SHALL have up_rstn, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in AXI_ADDRESS_WIDTH, cmd_wdata in 32: command channel.
REQ-006 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_rdata out 32, rsp_resp out 2, rsp_timeout out 1: response channel.
REQ-007 SHALL have m_axi_awvalid out 1, m_axi_awaddr out AXI_ADDRESS_WIDTH, m_axi_awprot out 3, m_axi_awready in 1.
REQ-008 SHALL have m_axi_wvalid out 1, m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wready in 1.
REQ-009 SHALL have m_axi_bvalid in 1, m_axi_bresp in 2, m_axi_bready out 1.
REQ-010 SHALL have m_axi_arvalid out 1, m_axi_araddr out AXI_ADDRESS_WIDTH, m_axi_arprot out 3, m_axi_arready in 1.
REQ-011 SHALL have m_axi_rvalid in 1, m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rready out 1.

Function
REQ-012 SHALL be an AXI4-Lite initiator issuing one transaction at a time to the JESD204 link register map; at most one outstanding.
REQ-013 SHALL implement states IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
REQ-014 IDLE: cmd_ready=1; cmd_valid&cmd_ready SHALL register addr/data/write and go to WADDR (write) or RADDR (read) next cycle.
REQ-015 WADDR: awvalid and wvalid SHALL assert together; each SHALL drop individually the cycle after its ready is sampled high; go to WRESP once both handshakes are done, including same-cycle completion.
REQ-016 WRESP: bready=1; on bvalid SHALL capture bresp into rsp_resp, set rsp_rdata=0, go to RESP.
REQ-017 RADDR: arvalid=1 until arready; then RDATA with rready=1; on rvalid SHALL capture rdata/rresp, go to RESP.
REQ-018 RESP: rsp_valid=1 with stable rsp_* fields until rsp_ready; then IDLE. Minimum command-to-rsp_valid latency is 3 cycles with zero-wait responder.
REQ-019 awvalid/wvalid/arvalid, once asserted, SHALL NOT drop before the matching ready (AXI rule), except on timeout (REQ-025).
REQ-020 wstrb SHALL be 4'hf; awprot/arprot SHALL be 3'b000; addresses SHALL have bits [1:0] forced to 0.
REQ-021 cmd_ready SHALL be 0 in every state except IDLE; a cmd_valid outside IDLE SHALL be ignored.
REQ-022 rsp_resp SHALL pass SLVERR/DECERR unmodified; the block SHALL NOT retry.

Reset
REQ-023 up_rstn low SHALL force, asynchronously: state IDLE, all m_axi valid/ready outputs 0, cmd_ready 0 while asserted, rsp_valid 0, rsp_rdata 0, rsp_resp 0, rsp_timeout 0, timeout counter 0.
REQ-024 Reset mid-transaction SHALL abandon the transaction without emitting a response; cmd_ready=1 the first cycle after release.

Configuration
REQ-025 With JESD204_AXI_MASTER_TIMEOUT_EN defined: a counter SHALL clear on entry to WADDR/RADDR and increment each cycle in WADDR/WRESP/RADDR/RDATA; at TIMEOUT_CYCLES it SHALL drop all m_axi valid/ready, go to RESP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-026 Without the macro: no counter logic; the block SHALL wait indefinitely; rsp_timeout SHALL be tied 0.

Verification
REQ-027 Write 0x0210 data 0x0000_0003, zero-wait responder, bresp=0 -> one AW and one W beat, rsp_valid at cycle 3, rsp_resp=0.
REQ-028 Read 0x0000, responder returns 0x0001_0661 after 5 wait cycles -> arvalid held 1 throughout, rsp_rdata=0x0001_0661.
REQ-029 Write with wready 4 cycles before awready -> wvalid drops after its handshake, awvalid held, exactly one of each handshake, one response.
REQ-030 Read with rresp=2'b10, rsp_ready held low 10 cycles -> rsp_valid and rsp_resp=2'b10 stable all 10 cycles, cmd_ready=0.
REQ-031 With macro, TIMEOUT_CYCLES=16, responder never asserts arready -> arvalid drops after 16 cycles, rsp_timeout=1, rsp_resp=2'b10.
REQ-032 up_rstn pulsed low during WRESP -> all outputs at reset values immediately, no rsp_valid, next command completes normally.
